// File: rtl/mtl_video_out.sv
// MTL 800x480 panel timing stage: locks an Avalon-ST RGB frame stream to the raster
// counters and drives registered hsync/vsync/RGB plus frame and error status.
module mtl_video_out #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 210,
  parameter int H_SYNC   = 30,
  parameter int H_BP     = 16,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 22,
  parameter int V_SYNC   = 13,
  parameter int V_BP     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        in_ready,
  output logic        mtl_hs,
  output logic        mtl_vs,
  output logic [7:0]  mtl_r,
  output logic [7:0]  mtl_g,
  output logic [7:0]  mtl_b,
  output logic        frame_start,
  output logic        underflow,
  output logic        sync_err,
  input  logic        clear_status
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_PIX_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_SYNC_S   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_E   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_PIX_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SYNC_S   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_E   = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_SEEK   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [23:0]   r_hold;
  logic [23:0]   r_rgb;
  logic [23:0]   w_rgb;
  logic          r_hs;
  logic          r_vs;
  logic          r_fs;
  logic          r_uf;
  logic          r_se;
  logic          w_active;
  logic          w_origin;
  logic          w_last;
  logic          w_ready;
  logic          w_accept;
  logic          w_hold_we;
  logic          w_set_uf;
  logic          w_set_se;

  assign w_active = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_origin = (r_h == {HW{1'b0}}) && (r_v == {VW{1'b0}});
  assign w_last   = (r_h == H_PIX_LAST) && (r_v == V_PIX_LAST);
  assign w_accept = in_valid && w_ready;

  // Raster position counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + VW'(1);
    end else begin
      r_h <= r_h + HW'(1);
    end
  end

  // Ready depends only on lock state and raster position.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      ST_SEEK:   w_ready = 1'b1;
      ST_WAIT:   w_ready = 1'b0;
      ST_STREAM: w_ready = w_active && !w_origin;
      default:   w_ready = 1'b0;
    endcase
  end

  assign in_ready = w_ready;

  // Lock state machine: next state, next pixel and error events.
  always_comb begin
    w_state_nxt = r_state;
    w_rgb       = 24'h000000;
    w_hold_we   = 1'b0;
    w_set_uf    = 1'b0;
    w_set_se    = 1'b0;
    case (r_state)
      ST_SEEK: begin
        if (w_accept && in_sop) begin
          w_hold_we   = 1'b1;
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_SEEK;
        end
      end
      ST_WAIT: begin
        if (w_origin) begin
          w_rgb       = r_hold;
          w_state_nxt = ST_STREAM;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_STREAM: begin
        // Pixel (0,0) comes from hold, so only the other active slots take data.
        if (!w_ready) begin
          w_state_nxt = ST_STREAM;
        end else if (!in_valid) begin
          w_set_uf    = 1'b1;
          w_state_nxt = ST_SEEK;
        end else if (in_sop) begin
          w_hold_we   = 1'b1;
          w_set_se    = 1'b1;
          w_state_nxt = ST_WAIT;
        end else if (in_eop) begin
          w_rgb       = in_data;
          w_set_se    = !w_last;
          w_state_nxt = ST_SEEK;
        end else if (w_last) begin
          w_rgb       = in_data;
          w_set_se    = 1'b1;
          w_state_nxt = ST_SEEK;
        end else begin
          w_rgb       = in_data;
          w_state_nxt = ST_STREAM;
        end
      end
      default: begin
        w_state_nxt = ST_SEEK;
      end
    endcase
  end

  // State and SOP hold register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_SEEK;
      r_hold  <= 24'h000000;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_we ? in_data : r_hold;
    end
  end

  // Registered panel outputs, one cycle behind the raster position.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_rgb <= 24'h000000;
      r_fs  <= 1'b0;
    end else begin
      r_hs  <= !((r_h >= H_SYNC_S) && (r_h < H_SYNC_E));
      r_vs  <= !((r_v >= V_SYNC_S) && (r_v < V_SYNC_E));
      r_rgb <= w_rgb;
      r_fs  <= w_origin;
    end
  end

  // Sticky status; a new error outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_uf <= 1'b0;
      r_se <= 1'b0;
    end else begin
      r_uf <= w_set_uf ? 1'b1 : (clear_status ? 1'b0 : r_uf);
      r_se <= w_set_se ? 1'b1 : (clear_status ? 1'b0 : r_se);
    end
  end

  assign mtl_hs      = r_hs;
  assign mtl_vs      = r_vs;
  assign mtl_r       = r_rgb[23:16];
  assign mtl_g       = r_rgb[15:8];
  assign mtl_b       = r_rgb[7:0];
  assign frame_start = r_fs;
  assign underflow   = r_uf;
  assign sync_err    = r_se;

endmodule

// File: tb/tb_mtl_video_out.sv
// Bench for mtl_video_out on a reduced raster: random frames are fed through a queue and
// each displayed frame is predicted as an image from the source frames and error points.
module tb_mtl_video_out;

  localparam int HA = 16, HF = 5, HS = 3, HB = 2;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int NPIX = HA * VA;
  localparam int NFR = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_sop, in_eop, clear_status, in_ready;
  logic [23:0] in_data;
  logic        mtl_hs, mtl_vs, frame_start, underflow, sync_err;
  logic [7:0]  mtl_r, mtl_g, mtl_b;

  mtl_video_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_sop(in_sop), .in_eop(in_eop), .in_ready(in_ready),
    .mtl_hs(mtl_hs), .mtl_vs(mtl_vs), .mtl_r(mtl_r), .mtl_g(mtl_g), .mtl_b(mtl_b),
    .frame_start(frame_start), .underflow(underflow), .sync_err(sync_err),
    .clear_status(clear_status)
  );

  int checks = 0;
  int errors = 0;
  int cyc, drop_at, clr_at, src_start;
  logic [25:0] q[$];
  logic [23:0] src [4][NPIX];
  logic [23:0] img [NFR][NPIX];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input int f, input int first, input int last);
    for (int i = first; i <= last; i++) q.push_back({(i == 0), (i == NPIX - 1), src[f][i]});
  endtask

  task automatic show(input int fd, input int s, input int upto);
    for (int i = 0; i < upto; i++) img[fd][i] = src[s][i];
  endtask

  task automatic do_reset();
    q.delete();
    for (int f = 0; f < NFR; f++)
      for (int i = 0; i < NPIX; i++) img[f][i] = 24'h0;
    drop_at = -1; clr_at = -1; src_start = 0;
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; clear_status = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_state", {mtl_hs, mtl_vs, in_ready, frame_start, underflow, sync_err, mtl_r, mtl_g, mtl_b},
        {6'b111000, 24'h0});
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  // One pixel clock: drive at negedge, model the handshake, check the registered output.
  task automatic step();
    logic acc;
    int pos, x, y, f;
    logic [23:0] px;
    in_valid = (q.size() > 0) && (cyc >= src_start) && (cyc != drop_at);
    if (q.size() > 0) {in_sop, in_eop, in_data} = q[0];
    else {in_sop, in_eop, in_data} = 26'h0;
    clear_status = (cyc == clr_at);
    acc = in_valid && in_ready;
    @(posedge clk);
    if (acc) void'(q.pop_front());
    cyc++;
    #1;
    pos = cyc - 1; x = pos % HT; y = (pos / HT) % VT; f = pos / FT;
    px = (x < HA && y < VA && f < NFR) ? img[f][y * HA + x] : 24'h0;
    chk($sformatf("raster f%0d x%0d y%0d", f, x, y),
        {5'd0, mtl_hs, mtl_vs, frame_start, mtl_r, mtl_g, mtl_b},
        {5'd0, !(x >= HA + HF && x < HA + HF + HS), !(y >= VA + VF && y < VA + VF + VS),
         (x == 0 && y == 0), px});
    @(negedge clk);
  endtask

  task automatic run(input int nf);
    repeat (nf * FT) step();
  endtask

  initial begin
    int n;
    logic [31:0] r;
    reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_data = 24'h0; clear_status = 1'b0; cyc = 0;
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < NPIX; i++) begin
        r = $urandom();
        src[f][i] = r[23:0];
      end

    // Gapless correct frames: frame k+1 shows source frame k.
    do_reset();
    for (int f = 0; f < 4; f++) begin
      push_frame(f, 0, NPIX - 1);
      show(f + 1, f, NPIX);
    end
    run(5);
    chk("flags_clean", {underflow, sync_err}, 2'b00);

    // Stream joins mid-frame with a frame tail; first SOP pixel shows at next (0,0).
    do_reset();
    src[0][0] = 24'hABCDEF;
    src_start = 100;
    push_frame(3, NPIX - 20, NPIX - 1);
    push_frame(0, 0, NPIX - 1);
    push_frame(1, 0, NPIX - 1);
    show(1, 0, NPIX);
    show(2, 1, NPIX);
    run(3);
    chk("midjoin_flags", {underflow, sync_err}, 2'b00);

    // Underflow at (10,3) of the first locked frame, then re-lock and clear.
    do_reset();
    for (int f = 0; f < 3; f++) push_frame(f, 0, NPIX - 1);
    drop_at = FT + 3 * HT + 10;
    show(1, 0, 3 * HA + 10);
    show(2, 1, NPIX);
    show(3, 2, NPIX);
    run(4);
    chk("underflow_set", {underflow, sync_err}, 2'b10);
    clr_at = cyc;
    step();
    chk("underflow_clr", {underflow, sync_err}, 2'b00);

    // Early EOP at (5,0) with a clear in the same cycle: set wins.
    do_reset();
    for (int f = 0; f < 3; f++) push_frame(f, 0, NPIX - 1);
    q[5][24] = 1'b1;
    clr_at = FT + 5;
    show(1, 0, 6);
    show(2, 1, NPIX);
    show(3, 2, NPIX);
    run(4);
    chk("early_eop", {underflow, sync_err}, 2'b01);

    // New SOP at (8,4) while streaming: black rest, held pixel at next (0,0).
    do_reset();
    push_frame(0, 0, 4 * HA + 7);
    push_frame(1, 0, NPIX - 1);
    push_frame(2, 0, NPIX - 1);
    show(1, 0, 4 * HA + 8);
    show(2, 1, NPIX);
    show(3, 2, NPIX);
    run(4);
    chk("mid_sop", {underflow, sync_err}, 2'b01);

    // Reset at (8,3) while streaming; first hsync low from counter zero.
    do_reset();
    push_frame(0, 0, NPIX - 1);
    push_frame(1, 0, NPIX - 1);
    show(1, 0, NPIX);
    repeat (FT + 3 * HT + 8) step();
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_mid", {mtl_hs, mtl_vs, in_ready, frame_start, underflow, sync_err, mtl_r, mtl_g, mtl_b},
        {6'b111000, 24'h0});
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    q.delete();
    n = 0;
    while (mtl_hs && n < 2 * HT) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hs_first_low", n, HA + HF + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
